// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the registered 1-to-NCH stream demultiplexer.
package stream_demux_pkg;

    typedef enum logic {IDLE, PKT} state_t;

    // Select width for a given channel count; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry output register with valid/ready; a load wins over a drain.
module stream_demux_slot #(
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          load,
    input  logic [DW-1:0] d_data,
    input  logic          d_last,
    input  logic          o_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_last
);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
        end else if (load) begin
            o_valid <= 1'b1;
            o_data  <= d_data;
            o_last  <= d_last;
        end else if (o_valid && o_ready) begin
            // Payload is left in place; only the valid bit drops.
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-NCH stream demux; the select is locked on a packet's first
// beat so multi-beat packets never split across channels.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int  DW  = 8,
    parameter int  NCH = 8,
    localparam int SW  = sel_width(NCH)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DW-1:0]     I_DATA,
    input  logic              I_VALID,
    input  logic              I_LAST,
    output logic              I_READY,
    input  logic [SW-1:0]     S,
    output logic [NCH*DW-1:0] O_DATA,
    output logic [NCH-1:0]    O_VALID,
    output logic [NCH-1:0]    O_LAST,
    input  logic [NCH-1:0]    O_READY,
    output logic              BUSY,
    output logic              ERR
);

    state_t                     state_q, state_d;
    logic [SW-1:0]              sel_q, sel_d;
    logic [SW-1:0]              target;
    logic                       in_range;
    logic                       slot_ready;
    logic                       accept;
    logic [NCH-1:0]             load;
    logic [NCH-1:0][DW-1:0]     slot_data;

    // Out-of-range targets keep slot_ready at 1 so the beat is swallowed.
    always_comb begin
        target     = (state_q == PKT) ? sel_q : S;
        in_range   = 1'b0;
        slot_ready = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            if (target == SW'(c)) begin
                in_range   = 1'b1;
                slot_ready = !O_VALID[c] || O_READY[c];
            end
        end
    end

    assign I_READY = slot_ready;
    assign accept  = I_VALID && I_READY;
    assign BUSY    = (state_q == PKT);
    assign O_DATA  = slot_data;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: if (accept && !I_LAST) begin
                state_d = PKT;
                sel_d   = S;
            end
            PKT:  if (accept && I_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ERR     <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            if (accept && !in_range) ERR <= 1'b1;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_slot
        assign load[c] = accept && (target == SW'(c));

        stream_demux_slot #(.DW(DW)) u_slot (
            .CLK     (CLK),
            .RST_N   (RST_N),
            .load    (load[c]),
            .d_data  (I_DATA),
            .d_last  (I_LAST),
            .o_ready (O_READY[c]),
            .o_valid (O_VALID[c]),
            .o_data  (slot_data[c]),
            .o_last  (O_LAST[c])
        );
    end

endmodule
